// File: rtl/mealy_bit_serializer.sv
// Byte-to-serial feeder for the Mealy "101" detector. A one-word holding register
// backs the shifter so consecutive words stream MSB-first with no idle bit period.
module mealy_bit_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             ena_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             bit_out_o,
   output logic             bit_valid_o,
   output logic             byte_done_o,
   output logic             busy_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             holdFull_q, holdFull_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] pre_q, pre_d;
   logic [DIV_W-1:0] divCap_q, divCap_d;
   logic             load;
   logic             bitEdge;

   assign bitEdge     = (state_q == SHIFT) && (pre_q == divCap_q);
   assign in_ready_o  = ena_i & ~holdFull_q;
   assign bit_out_o   = (state_q == SHIFT) & sreg_q[WIDTH-1];
   assign bit_valid_o = ena_i & bitEdge;
   assign byte_done_o = bit_valid_o & (cnt_q == LAST_CNT);
   assign busy_o      = (state_q == SHIFT) | holdFull_q;

   // A load can never coincide with an accept: loading needs holdFull_q, which blocks in_ready_o.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      holdFull_d = holdFull_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      pre_d      = pre_q;
      divCap_d   = divCap_q;
      load       = 1'b0;
      if (ena_i) begin
         if (in_valid_i && !holdFull_q) begin
            hold_d     = in_data_i;
            holdFull_d = 1'b1;
         end
         case (state_q)
            IDLE: load = holdFull_q;
            SHIFT: begin
               if (bitEdge) begin
                  pre_d = '0;
                  if (cnt_q != LAST_CNT) begin
                     sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                     cnt_d  = cnt_q + CNT_W'(1);
                  end else if (holdFull_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  pre_d = pre_q + DIV_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
         if (load) begin
            sreg_d     = hold_q;
            divCap_d   = div_i;
            cnt_d      = '0;
            pre_d      = '0;
            holdFull_d = 1'b0;
            state_d    = SHIFT;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         holdFull_q <= 1'b0;
         sreg_q     <= '0;
         cnt_q      <= '0;
         pre_q      <= '0;
         divCap_q   <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         holdFull_q <= holdFull_d;
         sreg_q     <= sreg_d;
         cnt_q      <= cnt_d;
         pre_q      <= pre_d;
         divCap_q   <= divCap_d;
      end
   end

endmodule

// File: tb/tb_mealy_bit_serializer.sv
// Directed bench for mealy_bit_serializer: a bit scoreboard is filled when a word is
// accepted and drained by a strobe monitor; timing checks use recorded strobe edges.
module tb_mealy_bit_serializer;

   logic       clk = 1'b0;
   logic       rstN;
   logic       ena;
   logic [3:0] div;
   logic [7:0] inData;
   logic       inValid;
   logic       inReady;
   logic       bitOut;
   logic       bitValid;
   logic       byteDone;
   logic       busy;

   int         compared   = 0;
   int         mismatched = 0;
   int         cyc        = 0;
   int         doneCnt    = 0;
   int         strobeEdges[$];
   logic [1:0] sb[$];

   mealy_bit_serializer #(.WIDTH(8), .DIV_W(4)) dut (
      .clk_i      (clk),
      .rst_n_i    (rstN),
      .ena_i      (ena),
      .div_i      (div),
      .in_data_i  (inData),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .bit_out_o  (bitOut),
      .bit_valid_o(bitValid),
      .byte_done_o(byteDone),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each strobe pops the next expected {bit, done} pair; a strobe with nothing queued is an error.
   always @(negedge clk) begin
      logic [1:0] e;
      if (bitValid === 1'b1) begin
         strobeEdges.push_back(cyc + 1);
         if (byteDone === 1'b1) doneCnt++;
         if (sb.size() == 0) begin
            checkOutput("extra_strobe", 32'(bitValid), 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("bit_out", 32'(bitOut), 32'(e[1]));
            checkOutput("byte_done", 32'(byteDone), 32'(e[0]));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] data, output int acceptEdge);
      bit ok;
      ok = 1'b0;
      acceptEdge = -1;
      @(negedge clk);
      inValid = 1'b1;
      inData  = data;
      for (int i = 0; i < 200; i++) begin
         if (inReady === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checkOutput("accept_timeout", 32'(inReady), 32'd1);
         inValid = 1'b0;
      end else begin
         for (int k = 0; k < 8; k++) sb.push_back({data[7-k], (k == 7) ? 1'b1 : 1'b0});
         @(posedge clk);
         #1;
         acceptEdge = cyc;
         inValid = 1'b0;
      end
   endtask

   task automatic waitStrobes(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #2;
         if (strobeEdges.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("strobe_timeout", 32'(strobeEdges.size()), 32'(n));
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      repeat (3) @(negedge clk);
      checkOutput("drain_busy", 32'(busy), 32'd0);
      checkOutput("drain_queue", 32'(sb.size()), 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(inReady), 32'd1);
      checkOutput({tag, "_bit_out"}, 32'(bitOut), 32'd0);
      checkOutput({tag, "_bit_valid"}, 32'(bitValid), 32'd0);
      checkOutput({tag, "_byte_done"}, 32'(byteDone), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int n2;
      int bad;
      rstN    = 1'b0;
      ena     = 1'b1;
      div     = 4'd0;
      inData  = 8'h00;
      inValid = 1'b0;

      // Reset values, and in_ready following ena.
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      checkResetOutputs("reset");
      ena = 1'b0;
      #1 checkOutput("ready_ena_low", 32'(inReady), 32'd0);
      ena = 1'b1;

      // Single word at full rate.
      strobeEdges.delete();
      doneCnt = 0;
      applyStimulus(8'hA5, n);
      waitIdle();
      checkOutput("single_first_edge", 32'(strobeEdges[0]), 32'(n + 2));
      checkOutput("single_span", 32'(strobeEdges[7] - strobeEdges[0]), 32'd7);
      checkOutput("single_count", 32'(strobeEdges.size()), 32'd8);
      checkOutput("single_done", 32'(doneCnt), 32'd1);

      // Back-to-back words with no gap.
      strobeEdges.delete();
      doneCnt = 0;
      applyStimulus(8'hA5, n);
      applyStimulus(8'h5A, n2);
      waitIdle();
      checkOutput("b2b_count", 32'(strobeEdges.size()), 32'd16);
      checkOutput("b2b_span", 32'(strobeEdges[15] - strobeEdges[0]), 32'd15);
      checkOutput("b2b_done", 32'(doneCnt), 32'd2);
      checkOutput("b2b_second_accept", 32'(n2 - n), 32'd2);

      // Prescaler: div captured at load, later changes ignored for the word in flight.
      strobeEdges.delete();
      div = 4'd3;
      applyStimulus(8'h80, n);
      waitStrobes(1);
      @(posedge clk);
      #1 div = 4'd0;
      waitIdle();
      checkOutput("pre_first_edge", 32'(strobeEdges[0]), 32'(n + 5));
      checkOutput("pre_count", 32'(strobeEdges.size()), 32'd8);
      bad = 0;
      for (int i = 1; i < strobeEdges.size(); i++)
         if (strobeEdges[i] - strobeEdges[i-1] != 4) bad++;
      checkOutput("pre_spacing", 32'(bad), 32'd0);

      // Backpressure: third word waits while the holding register is full.
      strobeEdges.delete();
      div = 4'd1;
      applyStimulus(8'h3C, n);
      applyStimulus(8'hC3, n);
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'h99;
      #1 checkOutput("bp_ready_low", 32'(inReady), 32'd0);
      applyStimulus(8'h99, n);
      waitIdle();
      checkOutput("bp_count", 32'(strobeEdges.size()), 32'd24);

      // Reset in the middle of a word.
      strobeEdges.delete();
      div = 4'd0;
      applyStimulus(8'hFF, n);
      waitStrobes(3);
      @(posedge clk);
      #1 rstN = 1'b0;
      @(posedge clk);
      #1 rstN = 1'b1;
      sb.delete();
      @(negedge clk);
      checkResetOutputs("midreset");
      repeat (20) @(negedge clk);
      checkOutput("midreset_strobes", 32'(strobeEdges.size()), 32'd4);

      // Enable freeze mid-word.
      strobeEdges.delete();
      applyStimulus(8'hB2, n);
      waitStrobes(3);
      @(posedge clk);
      #1 ena = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checkOutput("freeze_bit_valid", 32'(bitValid), 32'd0);
         checkOutput("freeze_in_ready", 32'(inReady), 32'd0);
      end
      @(posedge clk);
      #1 ena = 1'b1;
      waitIdle();
      checkOutput("freeze_count", 32'(strobeEdges.size()), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mealy_bit_serializer.md
# mealy_bit_serializer

Upstream feeder for the Mealy "101" sequence detector: accepts parallel bytes over a valid/ready handshake and emits them MSB-first as a strobed serial bit stream (`bit_out` qualified by `bit_valid`) that the detector samples. A programmable prescaler sets the bit period. A one-entry holding register lets consecutive bytes stream with no gap between them.

## Interface
- `WIDTH`, default 8, data word width in bits (≥2).
- `DIV_W`, default 4, prescaler width; bit period = `div`+1 clock cycles.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  design enable; low freezes all state.
- `div`  in  DIV_W  bit-period divisor, captured per word at load.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  holding register empty; a word is accepted on an edge where `in_valid` & `in_ready`.
- `bit_out`  out  1  current serial bit (shifter MSB).
- `bit_valid`  out  1  one-cycle strobe: sample `bit_out` on this edge.
- `byte_done`  out  1  high together with the last `bit_valid` of a word.
- `busy`  out  1  shifter active or holding register full.

## Operation
- Storage: holding register `hold` + `hold_full` flag; shift register `sreg`; bit counter `cnt` (0..WIDTH-1); prescaler `pre` (0..`div_q`); captured divisor `div_q`.
- States: IDLE, SHIFT.
- Accept: on edge with `ena` & `in_valid` & `in_ready`: `hold` ← `in_data`, `hold_full` ← 1. `in_ready` = `ena` & !`hold_full`.
- IDLE: if `hold_full` → load: `sreg` ← `hold`, `div_q` ← `div`, `cnt` ← 0, `pre` ← 0, `hold_full` ← 0, go SHIFT.
- SHIFT, `pre` < `div_q`: `pre` ← `pre`+1.
- SHIFT, `pre` == `div_q` (bit edge): `bit_valid` high this cycle; `pre` ← 0.
  - `cnt` < WIDTH-1: `sreg` shifts left (zero fill), `cnt` ← `cnt`+1.
  - `cnt` == WIDTH-1 (`byte_done` high): if `hold_full`, load the next word on this same edge (as in IDLE, stay SHIFT); else go IDLE.
- `bit_out` = `sreg[WIDTH-1]` in SHIFT, 0 in IDLE. `bit_valid` = `ena` & SHIFT & (`pre` == `div_q`). `byte_done` = `bit_valid` & (`cnt` == WIDTH-1). `busy` = SHIFT | `hold_full`.
- Accept and load never coincide: a load requires `hold_full`=1, which holds `in_ready` low.
- `div` changes take effect only at the next load; a word in flight keeps `div_q`.
- `ena` low: no register updates; `in_ready`, `bit_valid`, `byte_done` forced 0; state resumes unchanged when `ena` returns high.
- Reset (edge with `rst_n`=0, any state): IDLE, `hold_full`=0, `sreg`=0, `cnt`=0, `pre`=0, `div_q`=0. In-flight and held words are discarded.

## Timing
- Reset values: `in_ready`=`ena`, `bit_out`=0, `bit_valid`=0, `byte_done`=0, `busy`=0.
- All outputs are decodes of registers plus `ena`; no combinational path from `in_valid`/`in_data` to any output.
- Latency: word accepted at edge N (IDLE) → loaded at N+1 → first `bit_valid` sampled at edge N+2+`div`.
- Bit k (MSB = 0) is sampled at edge N+2+`div`+k·(`div`+1).
- Throughput: with the next word held before `byte_done`, the next word's first bit follows exactly `div`+1 cycles after the last bit, with no idle gap.
- `in_ready` returns high the cycle after the load edge; minimum accept spacing is 2 cycles.

## Test plan
- Single word: reset, `div`=0, send 0xA5 → `bit_valid` high 8 consecutive cycles with `bit_out` = 1,0,1,0,0,1,0,1; `byte_done` on the 8th; then `busy`=0.
- Back-to-back: `div`=0, send 0xA5, then 0x5A as soon as `in_ready` is high → 16 consecutive `bit_valid` cycles with no gap, bits 10100101 01011010, `byte_done` exactly twice.
- Prescaler: `div`=3, send 0x80 → first `bit_valid` at edge N+5, then every 4 cycles, 8 strobes total; changing `div` to 0 mid-word leaves spacing at 4.
- Backpressure: hold a word while shifting → `in_ready`=0 and `in_valid` ignored until the load edge; no word lost or duplicated.
- Reset mid-word: assert `rst_n`=0 for one edge after 3 bits of 0xFF → all outputs take reset values next cycle, no further `bit_valid`.
- Enable freeze: drop `ena` for 5 cycles mid-word with `div`=0 → no strobes during the freeze; the remaining bits resume in order with none skipped.
